// File: rtl/seq_logic_unit.sv
// ---------------------------------------------------------------------------
// seq_logic_unit
//
// Purpose:
//   Applies a bitwise logic operation (AND / OR / XOR / NOR) to two WIDTH-bit
//   operands, SLICE bits per clock. Operands and the op code are latched when
//   the block accepts start. The result is then built one slice per cycle.
//   Once the last slice is written, result and zero are held until the
//   consumer acknowledges them.
//
// Handshake (valid/ready):
//   - start is accepted only on an edge where in_ready=1; at any other time
//     start is ignored.
//   - result/zero are valid while result_valid=1. They stay stable until ack=1
//     is sampled on an edge while result_valid=1. ack at any other time is
//     ignored.
//   - When start and ack are high in the same HOLD cycle, the block only
//     retires the held result. The new start must be presented again once
//     in_ready=1.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   start        request to start an operation (sampled only in IDLE)
//   op           00 AND, 01 OR, 10 XOR, 11 NOR
//   a, b         operands (WIDTH bits)
//   ack          consumer has taken the result (sampled only in HOLD)
//   in_ready     block can accept start (IDLE)
//   busy         operation in progress (RUN)
//   result_valid result and zero are valid (HOLD)
//   result       operation result, retained after the operation finishes
//   zero         high when result is all zeros
//
// Parameters:
//   WIDTH  operand/result width; must be a nonzero multiple of SLICE
//   SLICE  bits processed per clock
// ---------------------------------------------------------------------------
module seq_logic_unit #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ack,
  output logic             in_ready,
  output logic             busy,
  output logic             result_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam int NSLICE = WIDTH / SLICE;
  // The counter always has at least one bit, even when NSLICE = 1.
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOR = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  // Operands and op code, frozen at acceptance.
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [1:0]       op_q;
  logic [CNT_W-1:0] cnt;

  logic             accept;
  logic             last_slice;
  logic [WIDTH-1:0] op_full;
  logic [WIDTH-1:0] result_next;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic and output decode.
  // The outputs depend on the state only, so no input reaches an output
  // combinationally.
  // -------------------------------------------------------------------------
  always_comb begin
    state_next   = state;
    in_ready     = 1'b0;
    busy         = 1'b0;
    result_valid = 1'b0;
    accept       = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_slice) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        result_valid = 1'b1;
        // start is deliberately not looked at here, even when it is high
        // together with ack.
        if (ack) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath
  // -------------------------------------------------------------------------
  assign last_slice = (cnt == CNT_W'(NSLICE - 1));

  // The op is evaluated over the full width. Only the slice the counter
  // selects is committed to result on each RUN edge.
  always_comb begin
    op_full = '0;
    unique case (op_q)
      OP_AND:  op_full = a_q & b_q;
      OP_OR:   op_full = a_q | b_q;
      OP_XOR:  op_full = a_q ^ b_q;
      OP_NOR:  op_full = ~(a_q | b_q);
      default: op_full = '0;
    endcase
  end

  // Slices the counter does not select keep their previous value.
  always_comb begin
    result_next = result;
    for (int k = 0; k < NSLICE; k++) begin
      if (cnt == CNT_W'(k)) begin
        result_next[k*SLICE +: SLICE] = op_full[k*SLICE +: SLICE];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      cnt    <= '0;
      result <= '0;
      zero   <= 1'b0;
    end else begin
      if (accept) begin
        a_q  <= a;
        b_q  <= b;
        op_q <= op;
        cnt  <= '0;
      end else if (state == RUN) begin
        result <= result_next;
        cnt    <= cnt + 1'b1;
        // zero is taken from the complete new result, including the slice
        // written on this same edge.
        if (last_slice) begin
          zero <= ~|result_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_logic_unit.sv
// ---------------------------------------------------------------------------
// tb_seq_logic_unit
//
// Purpose:
//   Directed bench for seq_logic_unit. It has two instances:
//   - u_dut:   WIDTH=32, SLICE=8 (4 slices)
//   - u_dut16: WIDTH=16, SLICE=16 (single slice)
//   Expected {zero, result} pairs are computed by hand. They are pushed into
//   exp_q when an operation is started and popped when result_valid rises.
// ---------------------------------------------------------------------------
module tb_seq_logic_unit;

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 32/8 instance
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        ack;
  logic        in_ready;
  logic        busy;
  logic        result_valid;
  logic [31:0] result;
  logic        zero;

  // 16/16 instance
  logic        s_start;
  logic [1:0]  s_op;
  logic [15:0] s_a;
  logic [15:0] s_b;
  logic        s_ack;
  logic        s_in_ready;
  logic        s_busy;
  logic        s_result_valid;
  logic [15:0] s_result;
  logic        s_zero;

  seq_logic_unit #(.WIDTH(32), .SLICE(8)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .op           (op),
    .a            (a),
    .b            (b),
    .ack          (ack),
    .in_ready     (in_ready),
    .busy         (busy),
    .result_valid (result_valid),
    .result       (result),
    .zero         (zero)
  );

  seq_logic_unit #(.WIDTH(16), .SLICE(16)) u_dut16 (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (s_start),
    .op           (s_op),
    .a            (s_a),
    .b            (s_b),
    .ack          (s_ack),
    .in_ready     (s_in_ready),
    .busy         (s_busy),
    .result_valid (s_result_valid),
    .result       (s_result),
    .zero         (s_zero)
  );

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOR = 2'b11;

  // -------------------------------------------------------------------------
  // Scoreboard
  // -------------------------------------------------------------------------
  logic [32:0] exp_q[$];   // {zero, result}
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // -------------------------------------------------------------------------
  // Driver tasks (32/8 instance). All driving happens 1 time unit after a
  // rising edge, and sampling happens at the same point.
  // -------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present start with the operands and take one edge. The expected value is
  // queued for the scoreboard.
  task automatic start_op(input string tag, input logic [1:0] o,
                          input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] exp_res, input logic exp_zero);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    exp_q.push_back({exp_zero, exp_res});
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    tick();
    start = 1'b0;
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
  endtask

  // Count edges until result_valid rises (bounded), then compare against
  // the scoreboard.
  task automatic wait_valid(input string tag, input int exp_edges);
    int n;
    logic [32:0] e;
    n = 0;
    while (!result_valid && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, n, exp_edges);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_result"}, result, e[31:0]);
      check({tag, "_zero"}, {31'd0, zero}, {31'd0, e[32]});
    end else begin
      check({tag, "_exp_q_empty"}, 32'd0, 32'd1);
    end
  endtask

  task automatic do_ack(input string tag);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check({tag, "_ack_in_ready"}, {31'd0, in_ready}, 32'd1);
    check({tag, "_ack_valid"}, {31'd0, result_valid}, 32'd0);
  endtask

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  initial begin
    rst_n   = 1'b0;
    start   = 1'b1;       // reset has priority over start
    op      = OP_OR;
    a       = 32'h0000_0000;
    b       = 32'hFFFF_FFFF;
    ack     = 1'b0;
    s_start = 1'b0;
    s_op    = OP_AND;
    s_a     = '0;
    s_b     = '0;
    s_ack   = 1'b0;

    repeat (3) tick();
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_valid", {31'd0, result_valid}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_zero", {31'd0, zero}, 32'd0);
    check("rst16_in_ready", {31'd0, s_in_ready}, 32'd1);

    // The first edge with rst_n=1 accepts the start that is already pending.
    // OR 0 | FFFFFFFF.
    exp_q.push_back({1'b0, 32'hFFFF_FFFF});
    rst_n = 1'b1;
    tick();
    start = 1'b0;
    check("or_first_accept", {31'd0, busy}, 32'd1);
    wait_valid("or", 4);
    do_ack("or");

    // AND 0003FFFF & 0.
    start_op("and", OP_AND, 32'h0003_FFFF, 32'h0000_0000, 32'h0000_0000, 1'b1);
    wait_valid("and", 4);
    do_ack("and");

    // XOR, then NOR back to back.
    start_op("xor", OP_XOR, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    wait_valid("xor", 4);
    do_ack("xor");
    start_op("nor", OP_NOR, 32'h0003_FFFF, 32'h0000_0000, 32'hFFFC_0000, 1'b0);
    wait_valid("nor", 4);
    do_ack("nor");

    // Change the inputs and pulse start during RUN.
    // 12345678 & F0F0F0F0 = 10305070.
    start_op("freeze", OP_AND, 32'h1234_5678, 32'hF0F0_F0F0, 32'h1030_5070, 1'b0);
    op    = OP_OR;
    a     = 32'hFFFF_FFFF;
    b     = 32'hFFFF_FFFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("freeze_still_busy", {31'd0, busy}, 32'd1);
    wait_valid("freeze", 3);
    do_ack("freeze");
    tick();
    check("freeze_no_second_op", {31'd0, in_ready}, 32'd1);
    check("freeze_result_retained", result, 32'h1030_5070);

    // HOLD stability, then ack and start together.
    // A5A5A5A5 ^ 0F0F0F0F = AAAAAAAA.
    start_op("hold", OP_XOR, 32'hA5A5_A5A5, 32'h0F0F_0F0F, 32'hAAAA_AAAA, 1'b0);
    wait_valid("hold", 4);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold_valid", {31'd0, result_valid}, 32'd1);
      check("hold_result", result, 32'hAAAA_AAAA);
      check("hold_zero", {31'd0, zero}, 32'd0);
    end
    ack   = 1'b1;
    start = 1'b1;
    op    = OP_OR;
    a     = 32'h0000_0001;
    b     = 32'h0000_0000;
    tick();
    ack   = 1'b0;
    start = 1'b0;
    check("ackstart_in_ready", {31'd0, in_ready}, 32'd1);
    check("ackstart_busy", {31'd0, busy}, 32'd0);
    check("ackstart_valid", {31'd0, result_valid}, 32'd0);
    tick();
    check("ackstart_not_accepted", {31'd0, in_ready}, 32'd1);
    check("idle_result_retained", result, 32'hAAAA_AAAA);

    // Reset in the middle of RUN.
    start = 1'b1;
    op    = OP_OR;
    a     = 32'h0000_0000;
    b     = 32'hFFFF_FFFF;
    tick();
    start = 1'b0;
    check("midrst_busy", {31'd0, busy}, 32'd1);
    tick();                 // slice 0 written
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    check("midrst_busy_low", {31'd0, busy}, 32'd0);
    check("midrst_result", result, 32'd0);
    check("midrst_zero", {31'd0, zero}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      check("midrst_no_valid", {31'd0, result_valid}, 32'd0);
      tick();
    end
    // FFFF0000 & 0FF00FF0 = 0FF00000.
    start_op("post_rst", OP_AND, 32'hFFFF_0000, 32'h0FF0_0FF0, 32'h0FF0_0000, 1'b0);
    wait_valid("post_rst", 4);
    do_ack("post_rst");

    // Single-slice instance: OR 00F0 | 0F00 = 0FF0, valid one edge later.
    check("w16_in_ready", {31'd0, s_in_ready}, 32'd1);
    s_start = 1'b1;
    s_op    = OP_OR;
    s_a     = 16'h00F0;
    s_b     = 16'h0F00;
    tick();
    s_start = 1'b0;
    check("w16_busy", {31'd0, s_busy}, 32'd1);
    tick();
    check("w16_valid", {31'd0, s_result_valid}, 32'd1);
    check("w16_result", {16'd0, s_result}, 32'h0000_0FF0);
    check("w16_zero", {31'd0, s_zero}, 32'd0);
    s_ack = 1'b1;
    tick();
    s_ack = 1'b0;
    check("w16_ack_in_ready", {31'd0, s_in_ready}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global time bound so the run always ends with its summary line.
  initial begin
    #200000;
    check("timeout", 32'd0, 32'd1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
